// File: rtl/async_pkg.sv
// async_pkg: definitions shared by the asynchronous pipeline stages and the
// clocked receiver at its tail.
//   rx_state_e : receiver handshake state (IDLE waits for req, ACK waits for RTZ)
//   DATA_W_DEF : token width of the async pipeline data bus
package async_pkg;

  localparam int DATA_W_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: N-flop synchroniser for a single async-to-clk crossing.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear of every flop
//   d     : asynchronous input
//   q     : synchronised output, N edges behind d
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/async_rx_sink.sv
// async_rx_sink: clocked tail of the asynchronous 4-phase pipeline.
// Synchronises req_in, captures the bundled data_in into a first-word-fall-
// through FIFO, returns a 4-phase ack_in and presents a valid/ready stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_in, data_in     : 4-phase request and bundled data from the last stage
//   ack_in              : 4-phase acknowledge (straight from the state flop)
//   out_valid/ready/data: stream side, FIFO head
//   fill                : occupancy 0..DEPTH
module async_rx_sink
  import async_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       ack_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);

  logic              req_s;
  rx_state_e         state_q, state_d;
  logic              push, pop, full;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] last_q;

  sync_chain #(.N(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_in),
    .q     (req_s)
  );

  // Full uses the registered count only: a pop in this cycle frees the slot
  // for the next cycle, which keeps the write path off the consumer's ready.
  assign full      = (fill == FILL_W'(DEPTH));
  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  assign ack_in    = (state_q == ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (req_s && !full) begin
        push    = 1'b1;
        state_d = ACK;
      end
      ACK:  if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage needs no reset: entries are only read while fill says they hold
  // a token, and reset discards the contents by clearing fill.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_q <= mem[rd_ptr];
      end
      fill <= fill + FILL_W'(push) - FILL_W'(pop);
    end
  end

  // When empty the port keeps showing the most recently popped token.
  assign out_data = out_valid ? mem[rd_ptr] : last_q;

endmodule

// File: tb/tb_async_rx_sink.sv
// tb_async_rx_sink: directed bench for async_rx_sink with a data scoreboard.
module tb_async_rx_sink;

  localparam int DATA_W = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        fill;

  int checks = 0;
  int errors = 0;
  int max_fill = 0;
  logic [DATA_W-1:0] sb[$];

  async_rx_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_in    (ack_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: a pop happening at this edge is scored first, then we land
  // 1 time unit after the edge where inputs are driven and outputs sampled.
  task automatic tick();
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
      else                check("pop_data", 32'(out_data), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
    if (int'(fill) > max_fill) max_fill = int'(fill);
  endtask

  task automatic wait_ack(input logic lvl, input int bound);
    for (int i = 0; i < bound && ack_in !== lvl; i++) tick();
    check("ack_wait", 32'(ack_in), 32'(lvl));
  endtask

  task automatic send_tok(input logic [DATA_W-1:0] d);
    data_in = d;
    req_in  = 1'b1;
    sb.push_back(d);
    wait_ack(1'b1, 40);
    req_in = 1'b0;
    wait_ack(1'b0, 40);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && fill != 0; i++) tick();
    out_ready = 1'b0;
    check("drain_fill", 32'(fill), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_in = 1'b0; data_in = '0; out_ready = 1'b0;
    #12;
    check("rst_ack", 32'(ack_in), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // single token: exact two-edge capture and release
    data_in = 3'd5; req_in = 1'b1; sb.push_back(3'd5);
    tick();
    check("single_ack_e0", 32'(ack_in), 32'd0);
    tick();
    check("single_ack_e1", 32'(ack_in), 32'd0);
    tick();
    check("single_ack_e2", 32'(ack_in), 32'd1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'd5);
    req_in = 1'b0;
    tick();
    check("rtz_e0", 32'(ack_in), 32'd1);
    tick();
    check("rtz_e1", 32'(ack_in), 32'd1);
    tick();
    check("rtz_e2", 32'(ack_in), 32'd0);
    drain();
    check("empty_hold", 32'(out_data), 32'd5);

    // fill to full, fifth request stalls until a pop frees a slot
    for (int k = 1; k <= 4; k++) send_tok(DATA_W'(k));
    check("full_fill", 32'(fill), 32'd4);
    data_in = 3'd5; req_in = 1'b1; sb.push_back(3'd5);
    for (int i = 0; i < 5; i++) tick();
    check("stall_ack", 32'(ack_in), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_no_write_ack", 32'(ack_in), 32'd0);
    check("pop_no_write_fill", 32'(fill), 32'd3);
    tick();
    check("late_write_ack", 32'(ack_in), 32'd1);
    check("late_write_fill", 32'(fill), 32'd4);
    req_in = 1'b0;
    wait_ack(1'b0, 40);
    drain();
    check("full_sb_empty", 32'(sb.size()), 32'd0);

    // stream order with a consumer that is always ready
    max_fill = 0;
    out_ready = 1'b1;
    send_tok(3'd7); send_tok(3'd0); send_tok(3'd3); send_tok(3'd6);
    drain();
    check("stream_max_fill", 32'(max_fill), 32'd1);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // pointer wrap: ten tokens through a four-deep FIFO
    for (int k = 0; k < 10; k++) begin
      send_tok(DATA_W'((k * 3 + 1) % 8));
      if (k % 3 == 2) drain();
    end
    drain();
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // reset while in ACK with three tokens stored
    send_tok(3'd1); send_tok(3'd2);
    data_in = 3'd3; req_in = 1'b1; sb.push_back(3'd3);
    wait_ack(1'b1, 40);
    check("pre_rst_fill", 32'(fill), 32'd3);
    #2;
    rst_n = 1'b0; req_in = 1'b0;
    #1;
    check("async_rst_ack", 32'(ack_in), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_fill", 32'(fill), 32'd0);
    sb.delete();
    tick(); tick();
    #2;
    rst_n = 1'b1;
    tick();
    send_tok(3'd2);
    check("post_rst_fill", 32'(fill), 32'd1);
    drain();

    // data changes only while acknowledged: captured value is the old one
    data_in = 3'd4; req_in = 1'b1; sb.push_back(3'd4);
    wait_ack(1'b1, 40);
    data_in = 3'd1;
    tick();
    req_in = 1'b0;
    wait_ack(1'b0, 40);
    check("hold_head", 32'(out_data), 32'd4);
    drain();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_rx_sink.md
# async_rx_sink

Clocked receiver at the tail of the asynchronous 4-phase pipeline. It consumes the `req_out`/`data_out` bundle of the last asynchronous stage, synchronises the request into the `clk` domain and captures the data into a small first-word-fall-through FIFO. It returns the acknowledge in 4-phase form and presents the tokens as a valid/ready stream to synchronous logic.

## Interface
- `DATA_W`, 3: token width; matches the pipeline data bus.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, 2: flops in the request synchroniser; at least 2.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: reset. Asynchronous, active-low.
- `req_in` input, 1 bit: 4-phase request from the last async stage. Asynchronous to `clk`.
- `data_in` input, `DATA_W` bits: bundled data. Stable from before `req_in` rises until `ack_in` is seen high.
- `ack_in` output, 1 bit: 4-phase acknowledge to the last async stage. Registered.
- `out_valid` output, 1 bit: the FIFO head is valid.
- `out_ready` input, 1 bit: the consumer accepts the head.
- `out_data` output, `DATA_W` bits: FIFO head.
- `fill` output, clog2(`DEPTH`+1) bits: current occupancy.

## Operation
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain on `req_in`, producing `req_s`. `data_in` is never synchronised; bundling guarantees it is stable when sampled.
- **FSM states:** IDLE, ACK.
  - IDLE, `ack_in`=0: if `req_s`=1 and the FIFO is not full, write `data_in` to the FIFO, set `ack_in`=1 and go to ACK. If `req_s`=1 and the FIFO is full, stall in IDLE with `ack_in` held at 0. No token is ever dropped.
  - ACK, `ack_in`=1: stay until `req_s`=0, then set `ack_in`=0 and go to IDLE. The return-to-zero half of the handshake is complete when `ack_in` falls.
- **FIFO:** pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
  - `fill` counts 0..`DEPTH`.
  - `out_valid` = (`fill` != 0).
  - Pop occurs when `out_valid` and `out_ready` are both 1.
  - **Full:** the full test uses the registered `fill`. A pop in the same cycle does not permit a write; the stalled write happens one cycle later.
  - **Simultaneous push and pop** when not full: `fill` is unchanged and both pointers advance.
  - **Empty:** `out_ready` has no effect and `out_data` holds its last value.
- **Reset:** while `rst_n`=0, asynchronously:
  - `ack_in`=0, `out_valid`=0, `fill`=0, `out_data`=0;
  - synchroniser cleared, pointers cleared, state IDLE.
- **Reset mid-handshake:** FIFO contents are discarded. The upstream stage shares `rst_n`, so `req_in` is 0 after reset and no stale token is re-captured.

## Timing
- `req_in` rising before edge 0 gives `req_s`=1 after edge `SYNC_STAGES`-1.
- **Capture:** `data_in` is captured and `ack_in` rises at edge `SYNC_STAGES`. That is 2 edges with defaults, jitter up to +1.
- `out_valid` rises on the same edge as `ack_in`. There is no extra latency to the stream side.
- **Return to zero:** `req_in` falling leads to `ack_in` falling `SYNC_STAGES` edges later.
- **Throughput:** at best one token per 2·(`SYNC_STAGES`+1) cycles, limited by the handshake.

## Structure
- **Shared package `async_pkg`:**
  - state enum (IDLE, ACK);
  - the `DATA_W` default of 3, shared with the async pipeline stages.
- **Sub-module `sync_chain`:** parameterised N-flop synchroniser with async active-low clear. It is reused for every async-to-`clk` crossing.
- The FIFO stays inline in `async_rx_sink`.

## Test plan
- **Single token:** `req_in`=1 with `data_in`=5 →
  - `ack_in`=1 exactly 2 edges later;
  - `out_valid`=1 with `out_data`=5 on that edge;
  - after `req_in`=0, `ack_in`=0 two edges later.
- **Fill to full:** hold `out_ready`=0 and send tokens 1, 2, 3, 4, 5 →
  - `fill`=4;
  - the fifth request stalls with `ack_in`=0;
  - pulse `out_ready` for one cycle → 1 is popped, then 5 is written and `ack_in`=1 one cycle after the pop.
- **Stream order:** with `out_ready`=1 continuously, send tokens 7, 0, 3, 6 → outputs appear in that order and `fill` never exceeds 1.
- **Pointer wrap:** send and drain 10 tokens with `DEPTH`=4 → order is preserved across the wrap and `fill` ends at 0.
- **Reset mid-operation:** assert `rst_n`=0 while in ACK with `fill`=3 →
  - `ack_in`, `out_valid` and `fill` go to 0 immediately, without waiting for a clock edge;
  - after release, the next token is captured normally.
- **Unsynchronised data change:** change `data_in` only while `ack_in`=1 → the captured value is the pre-change one.
